// File: rtl/console_text_scheduler.sv
// Arbitrates one single-port text RAM between the display fetch path, host cell writes and a
// screen-clear engine; display fetches always win their slot.
module console_text_scheduler #(
  parameter int unsigned NUM_COLS      = 80,
  parameter int unsigned NUM_ROWS      = 30,
  parameter int unsigned FRAME_WIDTH   = 800,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT  = 525,
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [7:0]  wr_char,
  input  logic [7:0]  wr_attr,
  input  logic        clear_req,
  input  logic [7:0]  clear_char,
  input  logic [7:0]  clear_attr,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [7:0]  character,
  output logic [7:0]  attribute
);

  localparam logic [9:0]  EolSlot     = 10'(FRAME_WIDTH - 2);
  localparam logic [9:0]  GroupLimit  = 10'(SCREEN_WIDTH - 8);
  localparam logic [9:0]  LastLine    = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0]  ActiveLines = 10'(SCREEN_HEIGHT);
  localparam logic [11:0] LastCell    = 12'(NUM_COLS * NUM_ROWS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e      r_state;
  logic [11:0] r_ptr;
  logic        r_clear_busy;
  logic        r_clear_done;
  logic        r_rd_pending;
  logic [7:0]  r_char;
  logic [7:0]  r_attr;

  logic        w_eol;
  logic        w_fetch_slot;
  logic        w_fetch_rd;
  logic [9:0]  w_fetch_line;
  logic [5:0]  w_fetch_row;
  logic [6:0]  w_fetch_col;
  logic [11:0] w_fetch_addr;
  logic [11:0] w_wr_addr;
  logic        w_wr_in_range;
  logic        w_wr_fire;

  // The end-of-line slot prefetches column 0 of the next line, wrapping at frame end.
  assign w_eol        = (cx == EolSlot);
  assign w_fetch_slot = w_eol || ((cx < GroupLimit) && (cx[2:0] == 3'd6));
  assign w_fetch_line = !w_eol ? cy : ((cy == LastLine) ? 10'd0 : cy + 10'd1);
  assign w_fetch_row  = 6'(w_fetch_line >> 4);
  assign w_fetch_col  = w_eol ? 7'd0 : cx[9:3] + 7'd1;
  assign w_fetch_rd   = w_fetch_slot && (w_fetch_line < ActiveLines);
  assign w_fetch_addr = 12'(w_fetch_row) * 12'(NUM_COLS) + 12'(w_fetch_col);

  assign w_wr_addr     = 12'(wr_row) * 12'(NUM_COLS) + 12'(wr_col);
  assign w_wr_in_range = (32'(wr_col) < NUM_COLS) && (32'(wr_row) < NUM_ROWS);
  assign wr_ready      = (r_state == StIdle) && !w_fetch_slot && !clear_req;
  assign w_wr_fire     = wr_valid && wr_ready && w_wr_in_range;

  // Out-of-range writes still handshake but never reach the RAM.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rst_n) begin
      if (w_fetch_rd) begin
        ram_addr = w_fetch_addr;
      end else if (!w_fetch_slot && (r_state == StClear)) begin
        ram_addr  = r_ptr;
        ram_we    = 1'b1;
        ram_wdata = {clear_attr, clear_char};
      end else if (w_wr_fire) begin
        ram_addr  = w_wr_addr;
        ram_we    = 1'b1;
        ram_wdata = {wr_attr, wr_char};
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
      r_rd_pending <= 1'b0;
      r_char       <= '0;
      r_attr       <= '0;
    end else begin
      r_clear_done <= 1'b0;
      r_rd_pending <= w_fetch_rd;
      if (r_rd_pending) begin
        {r_attr, r_char} <= ram_rdata;
      end
      case (r_state)
        StIdle: begin
          if (clear_req) begin
            r_state      <= StClear;
            r_ptr        <= '0;
            r_clear_busy <= 1'b1;
          end
        end
        StClear: begin
          // Fetch slots stall the pointer; clear_req is ignored here.
          if (!w_fetch_slot) begin
            if (r_ptr == LastCell) begin
              r_state      <= StIdle;
              r_ptr        <= '0;
              r_clear_busy <= 1'b0;
              r_clear_done <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 12'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;
  assign character  = r_char;
  assign attribute  = r_attr;

endmodule

// File: doc/console_text_scheduler.md
CONSOLE_TEXT_SCHEDULER -- requirements
Module: console_text_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 80, text columns.
REQ-002 SHALL have parameter NUM_ROWS, default 30, text rows of 16 pixel lines.
REQ-003 SHALL have parameter FRAME_WIDTH, default 800, total pixels per line; SCREEN_WIDTH, default 640, active pixels per line.
REQ-004 SHALL have parameter FRAME_HEIGHT, default 525, total lines; SCREEN_HEIGHT, default 480, active lines.
REQ-005 SHALL have ports: clk_pixel in 1, pixel clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: cx in 10, current pixel column; cy in 10, current line.
REQ-007 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_col in 7; wr_row in 5; wr_char in 8; wr_attr in 8 (host write request).
REQ-008 SHALL have ports: clear_req in 1, clear-screen strobe; clear_char in 8; clear_attr in 8; clear_busy out 1; clear_done out 1 (one-cycle pulse).
REQ-009 SHALL have ports: ram_addr out 12; ram_we out 1; ram_wdata out 16 ({attr,char}); ram_rdata in 16 (single-port RAM, 1-cycle synchronous read).
REQ-010 SHALL have ports: character out 8; attribute out 8, feeding the console glyph renderer.

Function
REQ-011 Cell address SHALL be row*NUM_COLS+col, 12-bit, unsigned; max 2399 at defaults.
REQ-012 Fetch slot SHALL be the cycle where cx==FRAME_WIDTH-2, or cx<SCREEN_WIDTH-8 with cx[2:0]==6.
REQ-013 In a fetch slot, col SHALL be 0 when cx==FRAME_WIDTH-2, else cx[9:3]+1; row SHALL be next line's cy[9:4] (cy+1, wrapping FRAME_HEIGHT-1 to 0) when cx==FRAME_WIDTH-2, else cy[9:4].
REQ-014 Fetch slot SHALL drive ram_addr to the fetch cell with ram_we=0 only if the fetch line is < SCREEN_HEIGHT; otherwise slot stays reserved but issues no read.
REQ-015 ram_rdata SHALL be registered into {attribute,character} on the cycle after a fetch read, so new values appear when cx[2:0]==0 of the fetched cell; held otherwise.
REQ-016 Fetch SHALL have absolute priority; display read never delayed or skipped.
REQ-017 States SHALL be IDLE and CLEAR.
REQ-018 IDLE: wr_ready=1 iff not fetch slot (combinational); wr_valid&&wr_ready SHALL drive ram_we=1, addr per REQ-011, wdata={wr_attr,wr_char} same cycle.
REQ-019 Write with wr_col>=NUM_COLS or wr_row>=NUM_ROWS SHALL be accepted (handshake completes) and dropped (ram_we=0).
REQ-020 IDLE with clear_req=1 SHALL enter CLEAR next cycle, clear pointer=0, clear_busy=1; clear_req and wr_valid together: clear wins, write not accepted (wr_ready=0 that cycle).
REQ-021 CLEAR: wr_ready=0; each non-fetch cycle SHALL write {clear_attr,clear_char} at pointer and increment; fetch cycles stall pointer.
REQ-022 After writing address NUM_COLS*NUM_ROWS-1, SHALL return to IDLE, clear_busy=0, clear_done=1 for exactly one cycle.
REQ-023 clear_req during CLEAR SHALL be ignored (no restart).
REQ-024 clear_char/clear_attr SHALL be sampled live each clear write (not captured).

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, pointer 0, character=0x00, attribute=0x00, clear_busy=0, clear_done=0, ram_we=0, ram_addr=0.
REQ-026 Reset mid-CLEAR SHALL abort; no clear_done; partially cleared RAM left as-is.
REQ-027 After rst_n release, first fetch slot SHALL behave per REQ-012..015 with no warm-up.

Verification
REQ-028 Write col=5,row=2,char=0x41,attr=0x0F at non-fetch cycle -> ram_we=1, ram_addr=165, ram_wdata=0x0F41 same cycle.
REQ-029 wr_valid held across cx=6 on line 0 -> wr_ready=0 at cx=6, ram_addr=1 read; accept at cx=7; character/attribute update at cx=8 from RAM addr 1.
REQ-030 cx=798, cy=15 -> read addr 80 (row 1 col 0); cx=798, cy=479 -> no read; cx=798, cy=524 -> read addr 0.
REQ-031 Write col=80,row=0 -> handshake completes, ram_we stays 0.
REQ-032 clear_req pulse with clear_char=0x20, clear_attr=0x07 -> addrs 0..2399 each written 0x0720 exactly once, no fetch slot used, clear_done one pulse, wr_ready low throughout.
REQ-033 rst_n low at clear pointer 1000 -> outputs to reset values immediately; no clear_done; next clear_req restarts at 0.
